demux_1para4_buffer: RTL and testbench

//  Inverse of the 4:1 datapath selector: routes one 8-bit input stream to one of four

---
 rtl/nrisc_pkg.sv | 27 ++
 rtl/fifo_canal.sv | 58 +++++
 rtl/demux_1para4_buffer.sv | 68 ++++++
 tb/tb_demux_1para4_buffer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// Shared nRisc datapath constants: data width, channel count and the
// destination encodings used by the output-stage demultiplexer.
package nrisc_pkg;

  localparam int LARGURA_DADO = 8;
  localparam int NUM_CANAIS   = 4;

  localparam logic [1:0] SEL_SAIDA1 = 2'b00;
  localparam logic [1:0] SEL_SAIDA2 = 2'b01;
  localparam logic [1:0] SEL_SAIDA3 = 2'b10;
  localparam logic [1:0] SEL_SAIDA4 = 2'b11;

  // One-hot channel mask for a destination code; bit i selects saida(i+1).
  function automatic logic [NUM_CANAIS-1:0] decodifica_sel(input logic [1:0] sel);
    logic [NUM_CANAIS-1:0] mascara;
    mascara = '0;
    case (sel)
      SEL_SAIDA1: mascara = 4'b0001;
      SEL_SAIDA2: mascara = 4'b0010;
      SEL_SAIDA3: mascara = 4'b0100;
      SEL_SAIDA4: mascara = 4'b1000;
      default:    mascara = '0;
    endcase
    return mascara;
  endfunction

endpackage

// File: rtl/fifo_canal.sv
// Synchronous per-channel FIFO with explicit fill count; reset and limpar
// both empty it and wipe storage so nothing stale can reach the output.
module fifo_canal
  import nrisc_pkg::*;
#(
  parameter int LARGURA      = LARGURA_DADO,
  parameter int PROFUNDIDADE = 2,
  localparam int PW = $clog2(PROFUNDIDADE),
  localparam int CW = PW + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               limpar,
  input  logic               push,
  input  logic               pop,
  input  logic [LARGURA-1:0] dado_entrada,
  output logic [LARGURA-1:0] dado_saida,
  output logic               cheio,
  output logic               vazio,
  output logic [CW-1:0]      contagem
);

  localparam logic [CW-1:0] CONT_CHEIO = CW'(PROFUNDIDADE);

  logic [LARGURA-1:0] memoria [PROFUNDIDADE];
  logic [PW-1:0]      ptr_escrita;
  logic [PW-1:0]      ptr_leitura;
  logic               faz_push;
  logic               faz_pop;

  assign cheio      = (contagem == CONT_CHEIO);
  assign vazio      = (contagem == '0);
  assign faz_push   = push && !cheio;
  assign faz_pop    = pop && !vazio;
  assign dado_saida = memoria[ptr_leitura];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock) begin
    if (!reset || limpar) begin
      ptr_escrita <= '0;
      ptr_leitura <= '0;
      contagem    <= '0;
      for (int k = 0; k < PROFUNDIDADE; k++) memoria[k] <= '0;
    end else begin
      if (faz_push) begin
        memoria[ptr_escrita] <= dado_entrada;
        ptr_escrita          <= ptr_escrita + 1'b1;
      end
      if (faz_pop) ptr_leitura <= ptr_leitura + 1'b1;
      case ({faz_push, faz_pop})
        2'b10:   contagem <= contagem + 1'b1;
        2'b01:   contagem <= contagem - 1'b1;
        default: contagem <= contagem;
      endcase
    end
  end

endmodule

// File: rtl/demux_1para4_buffer.sv
// 1-to-4 buffered demultiplexer: routes entrada to the FIFO chosen by
// selecao; each channel drains independently through its own valid/ready.
//
// Handshake: a word moves when valid && ready are both high at a rising edge;
// while valid is high and ready low, data and valid stay stable. entrada_pronta
// depends only on selecao and registered fill state, never on saida_pronta.
module demux_1para4_buffer
  import nrisc_pkg::*;
#(
  parameter int LARGURA      = LARGURA_DADO,
  parameter int PROFUNDIDADE = 2,
  localparam int CW = $clog2(PROFUNDIDADE) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    limpar,
  input  logic [LARGURA-1:0]      entrada,
  input  logic [1:0]              selecao,
  input  logic                    entrada_valida,
  output logic                    entrada_pronta,
  output logic [LARGURA-1:0]      saida1,
  output logic [LARGURA-1:0]      saida2,
  output logic [LARGURA-1:0]      saida3,
  output logic [LARGURA-1:0]      saida4,
  output logic [NUM_CANAIS-1:0]   saida_valida,
  input  logic [NUM_CANAIS-1:0]   saida_pronta,
  output logic [NUM_CANAIS*CW-1:0] ocupacao
);

  logic [NUM_CANAIS-1:0] push;
  logic [NUM_CANAIS-1:0] pop;
  logic [NUM_CANAIS-1:0] cheio;
  logic [NUM_CANAIS-1:0] vazio;
  logic [LARGURA-1:0]    dado [NUM_CANAIS];
  logic [CW-1:0]         cont [NUM_CANAIS];

  assign entrada_pronta = !cheio[selecao];
  assign push = (entrada_valida && entrada_pronta) ? decodifica_sel(selecao) : '0;

  for (genvar g = 0; g < NUM_CANAIS; g++) begin : g_canal
    assign pop[g]          = !vazio[g] && saida_pronta[g];
    assign saida_valida[g] = !vazio[g];
    assign ocupacao[g*CW +: CW] = cont[g];

    fifo_canal #(
      .LARGURA      (LARGURA),
      .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .limpar       (limpar),
      .push         (push[g]),
      .pop          (pop[g]),
      .dado_entrada (entrada),
      .dado_saida   (dado[g]),
      .cheio        (cheio[g]),
      .vazio        (vazio[g]),
      .contagem     (cont[g])
    );
  end

  // Empty channels present zero rather than whatever the read slot last held.
  assign saida1 = saida_valida[0] ? dado[0] : '0;
  assign saida2 = saida_valida[1] ? dado[1] : '0;
  assign saida3 = saida_valida[2] ? dado[2] : '0;
  assign saida4 = saida_valida[3] ? dado[3] : '0;

endmodule

// File: tb/tb_demux_1para4_buffer.sv
// Randomised bench for demux_1para4_buffer: per-channel expected queues
// filled from stimulus, emptied by an output monitor, plus directed cases.
module tb_demux_1para4_buffer;

  localparam int P  = 2;
  localparam int CW = $clog2(P) + 1;

  logic          clock;
  logic          reset;
  logic          limpar;
  logic [7:0]    entrada;
  logic [1:0]    selecao;
  logic          entrada_valida;
  logic          entrada_pronta;
  logic [7:0]    saida1, saida2, saida3, saida4;
  logic [3:0]    saida_valida;
  logic [3:0]    saida_pronta;
  logic [4*CW-1:0] ocupacao;

  int n_checks = 0;
  int n_pass   = 0;
  bit primed   = 0;
  bit exp_pronta = 1;

  logic [7:0] exp_q[4][$];

  demux_1para4_buffer #(.LARGURA(8), .PROFUNDIDADE(P)) dut (
    .clock          (clock),
    .reset          (reset),
    .limpar         (limpar),
    .entrada        (entrada),
    .selecao        (selecao),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .saida1         (saida1),
    .saida2         (saida2),
    .saida3         (saida3),
    .saida4         (saida4),
    .saida_valida   (saida_valida),
    .saida_pronta   (saida_pronta),
    .ocupacao       (ocupacao)
  );

  // clock / reset
  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] saida_de(input int i);
    case (i)
      0: return saida1;
      1: return saida2;
      2: return saida3;
      default: return saida4;
    endcase
  endfunction

  // driver
  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] p, input logic l, input logic r);
    @(posedge clock);
    #1;
    entrada_valida = v;
    selecao        = s;
    entrada        = d;
    saida_pronta   = p;
    limpar         = l;
    reset          = r;
  endtask

  // stimulus side of the scoreboard: a word is expected once accepted
  always @(posedge clock) begin
    primed <= 1;
    if (!reset || limpar) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end else if (entrada_valida && exp_pronta) begin
      exp_q[selecao].push_back(entrada);
    end
  end

  // output monitor: compare visible state, then retire handshaken words
  always @(negedge clock) begin
    if (primed) begin
      for (int i = 0; i < 4; i++) begin
        bit v;
        v = (exp_q[i].size() != 0);
        chk($sformatf("valid_ch%0d", i + 1), 32'(saida_valida[i]), 32'(v));
        chk($sformatf("data_ch%0d", i + 1), 32'(saida_de(i)), v ? 32'(exp_q[i][0]) : 32'd0);
        chk($sformatf("ocup_ch%0d", i + 1), 32'(ocupacao[i*CW +: CW]), 32'(exp_q[i].size()));
      end
      if (!$isunknown(selecao)) begin
        exp_pronta = (exp_q[selecao].size() < P);
        chk("entrada_pronta", 32'(entrada_pronta), 32'(exp_pronta));
      end
      for (int i = 0; i < 4; i++)
        if (exp_q[i].size() != 0 && saida_pronta[i]) void'(exp_q[i].pop_front());
    end
  end

  always @(posedge clock)
    if (reset === 1'b1 && entrada_valida === 1'b1)
      assert (!$isunknown(selecao)) else $error("FAIL selecao_x: selecao unknown with entrada_valida");

  initial begin
    reset = 0; limpar = 0; entrada = 0; selecao = 0;
    entrada_valida = 0; saida_pronta = 0;
    drive(0, 0, 8'h00, 4'h0, 0, 0);
    drive(0, 0, 8'h00, 4'h0, 0, 1);

    // test 2: single push to channel 3
    drive(1, 2'b10, 8'hA5, 4'h0, 0, 1);
    drive(0, 2'b00, 8'h00, 4'h0, 0, 1);
    @(negedge clock);
    chk("t2_saida3", 32'(saida3), 32'hA5);
    chk("t2_valid", 32'(saida_valida), 32'b0100);

    // test 3: fill channel 1
    drive(1, 2'b00, 8'h01, 4'h0, 0, 1);
    drive(1, 2'b00, 8'h02, 4'h0, 0, 1);
    drive(0, 2'b00, 8'h00, 4'h0, 0, 1);
    @(negedge clock);
    chk("t3_count_ch1", 32'(ocupacao[CW-1:0]), 32'd2);
    chk("t3_pronta_sel00", 32'(entrada_pronta), 32'd0);
    drive(0, 2'b01, 8'h00, 4'h0, 0, 1);
    @(negedge clock);
    chk("t3_pronta_sel01", 32'(entrada_pronta), 32'd1);
    drive(1, 2'b00, 8'h03, 4'h0, 0, 1);
    @(negedge clock);
    chk("t3_third_rejected", 32'(entrada_pronta), 32'd0);

    // test 4: full channel, push with pop -> pop only
    drive(1, 2'b00, 8'h03, 4'b0001, 0, 1);
    @(negedge clock);
    chk("t4_pronta", 32'(entrada_pronta), 32'd0);
    drive(0, 2'b00, 8'h00, 4'h0, 0, 1);
    @(negedge clock);
    chk("t4_count_ch1", 32'(ocupacao[CW-1:0]), 32'd1);
    chk("t4_saida1", 32'(saida1), 32'h02);

    // test 5: simultaneous push and pop on channel 2
    drive(1, 2'b01, 8'h11, 4'h0, 0, 1);
    drive(1, 2'b01, 8'h7E, 4'b0010, 0, 1);
    drive(0, 2'b01, 8'h00, 4'h0, 0, 1);
    @(negedge clock);
    chk("t5_count_ch2", 32'(ocupacao[2*CW-1:CW]), 32'd1);
    chk("t5_saida2", 32'(saida2), 32'h7E);

    // test 6a: load every channel then flush
    for (int i = 0; i < 4; i++) drive(1, 2'(i), 8'(8'h40 + i), 4'h0, 0, 1);
    drive(0, 2'b00, 8'h00, 4'h0, 1, 1);
    drive(0, 2'b00, 8'h00, 4'h0, 0, 1);
    @(negedge clock);
    chk("t6_flush_valid", 32'(saida_valida), 32'd0);
    chk("t6_flush_ocup", 32'(ocupacao), 32'd0);

    // test 1: reset for two cycles in the middle of traffic
    for (int i = 0; i < 6; i++) drive(1, 2'($urandom_range(0, 3)), 8'($urandom), 4'h0, 0, 1);
    drive(1, 2'b11, 8'hEE, 4'h0, 0, 0);
    drive(1, 2'b00, 8'hDD, 4'hF, 0, 0);
    drive(0, 2'b00, 8'h00, 4'h0, 0, 1);
    @(negedge clock);
    chk("t1_valid", 32'(saida_valida), 32'd0);
    chk("t1_ocup", 32'(ocupacao), 32'd0);
    chk("t1_saidas", {saida1, saida2, saida3, saida4}, 32'd0);
    chk("t1_pronta", 32'(entrada_pronta), 32'd1);

    // test 6b: long random run against the scoreboard
    for (int i = 0; i < 1500; i++)
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
            4'($urandom_range(0, 15)), 0, 1);

    // drain: every accepted word must come out
    for (int i = 0; i < 8; i++) drive(0, 2'b00, 8'h00, 4'hF, 0, 1);
    @(negedge clock);
    chk("drain_valid", 32'(saida_valida), 32'd0);
    chk("drain_ocup", 32'(ocupacao), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
